// File: rtl/crypto_pkg.sv
// Shared types and round arithmetic for the crypto stream engine.
// The round helpers work on a wide container type and take the live block
// width as an argument, so any BLOCK_WIDTH up to MAX_WIDTH reuses them.
package crypto_pkg;

  typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} crypto_mode_e;

  localparam int unsigned MAX_WIDTH = 256;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  // All-ones over the low bw bits of the container.
  function automatic wide_t width_mask(input int unsigned bw);
    if (bw >= MAX_WIDTH) return '1;
    return (wide_t'(1) << bw) - wide_t'(1);
  endfunction

  // Rotate left by one bit within a bw-bit block.
  function automatic wide_t rotl1(input wide_t x, input int unsigned bw);
    wide_t xm;
    xm = x & width_mask(bw);
    return ((xm << 1) | (xm >> (bw - 1))) & width_mask(bw);
  endfunction

  // Rotate right by one bit within a bw-bit block.
  function automatic wide_t rotr1(input wide_t x, input int unsigned bw);
    wide_t xm;
    xm = x & width_mask(bw);
    return ((xm >> 1) | (xm << (bw - 1))) & width_mask(bw);
  endfunction

  // Round key r: base key with the round index folded into the top byte.
  function automatic wide_t round_key(input wide_t key, input int unsigned r,
                                      input int unsigned bw);
    return (key ^ (wide_t'(r) << (bw - 8))) & width_mask(bw);
  endfunction

  // One encrypt round: mix in the key, then rotate left.
  function automatic wide_t enc_round(input wide_t x, input wide_t rk,
                                      input int unsigned bw);
    return rotl1(x ^ rk, bw);
  endfunction

  // One decrypt round: undo the rotate, then remove the key.
  function automatic wide_t dec_round(input wide_t x, input wide_t rk,
                                      input int unsigned bw);
    return (rotr1(x, bw) ^ rk) & width_mask(bw);
  endfunction

endpackage

// File: rtl/crypto_round_stage.sv
// One pipeline stage of the crypto stream engine: a valid/data/mode register
// loaded with the result of this stage's encrypt or decrypt round.
// Decrypt stages use the round keys in reverse order so that a block
// encrypted through the whole pipe decrypts back through the same pipe.
module crypto_round_stage
  import crypto_pkg::*;
#(
  parameter int BLOCK_WIDTH = 32,
  parameter int STAGE_IDX   = 0,
  parameter int NUM_ROUNDS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BLOCK_WIDTH-1:0] i_key,
  input  logic                   i_valid,
  input  logic [BLOCK_WIDTH-1:0] i_data,
  input  crypto_mode_e           i_mode,
  input  logic                   i_ready,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [BLOCK_WIDTH-1:0] o_data,
  output crypto_mode_e           o_mode
);

  localparam int unsigned ENC_ROUND = STAGE_IDX;
  localparam int unsigned DEC_ROUND = NUM_ROUNDS - 1 - STAGE_IDX;

  logic [BLOCK_WIDTH-1:0] w_enc_key;
  logic [BLOCK_WIDTH-1:0] w_dec_key;
  logic [BLOCK_WIDTH-1:0] w_next;
  logic                   r_valid;
  logic [BLOCK_WIDTH-1:0] r_data;
  crypto_mode_e           r_mode;

  assign w_enc_key = BLOCK_WIDTH'(round_key(wide_t'(i_key), ENC_ROUND, BLOCK_WIDTH));
  assign w_dec_key = BLOCK_WIDTH'(round_key(wide_t'(i_key), DEC_ROUND, BLOCK_WIDTH));

  // The stage can take a new block when it is empty or its block moves on.
  assign o_ready = !r_valid || i_ready;

  // Pick the round flavour from the mode that travels with the block.
  always_comb begin
    w_next = BLOCK_WIDTH'(enc_round(wide_t'(i_data), wide_t'(w_enc_key), BLOCK_WIDTH));
    if (i_mode == MODE_DEC) begin
      w_next = BLOCK_WIDTH'(dec_round(wide_t'(i_data), wide_t'(w_dec_key), BLOCK_WIDTH));
    end
  end

  // Advance when allowed; an empty upstream slot collapses into a bubble
  // while the payload is left untouched so stalled outputs stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_ENC;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_next;
        r_mode <= i_mode;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;

endmodule

// File: rtl/crypto_stream_engine.sv
// Fully pipelined block cipher lane: NUM_ROUNDS register stages, one round
// each, with valid/ready backpressure, per-block encrypt/decrypt mode and a
// runtime-loadable base key.
// Optional performance counters are built when CRYPTO_PERF_CNT_EN is
// defined; otherwise blocks_processed and cycles_elapsed are tied to 0.
module crypto_stream_engine
  import crypto_pkg::*;
#(
  parameter int                     BLOCK_WIDTH   = 32,
  parameter int                     NUM_ROUNDS    = 8,
  parameter logic [BLOCK_WIDTH-1:0] KEY_RESET     = BLOCK_WIDTH'(32'hDEADBEEF),
  parameter int                     COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BLOCK_WIDTH-1:0]   data_in,
  input  logic                     data_in_mode,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [BLOCK_WIDTH-1:0]   data_out,
  output logic                     data_out_mode,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  input  logic [BLOCK_WIDTH-1:0]   key_in,
  input  logic                     key_load,
  output logic                     key_load_err,
  output logic                     busy,
  output logic [COUNTER_WIDTH-1:0] blocks_processed,
  output logic [COUNTER_WIDTH-1:0] cycles_elapsed
);

  localparam int LAST = NUM_ROUNDS - 1;

  logic [BLOCK_WIDTH-1:0] r_key;
  logic                   r_key_err;
  logic [NUM_ROUNDS-1:0]  w_stage_valid;
  logic                   w_busy;

  // Each stage gets its neighbours through its own generate scope, which
  // keeps the ready chain as separate nets rather than one self-feeding vector.
  for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_stage
    logic                   w_in_valid;
    logic [BLOCK_WIDTH-1:0] w_in_data;
    crypto_mode_e           w_in_mode;
    logic                   w_dn_ready;
    logic                   w_rdy;
    logic                   w_valid;
    logic [BLOCK_WIDTH-1:0] w_data;
    crypto_mode_e           w_mode;

    if (i == 0) begin : g_head
      assign w_in_valid = data_in_valid;
      assign w_in_data  = data_in;
      assign w_in_mode  = crypto_mode_e'(data_in_mode);
    end else begin : g_link
      assign w_in_valid = g_stage[i-1].w_valid;
      assign w_in_data  = g_stage[i-1].w_data;
      assign w_in_mode  = g_stage[i-1].w_mode;
    end

    if (i == LAST) begin : g_tail
      assign w_dn_ready = data_out_ready;
    end else begin : g_body
      assign w_dn_ready = g_stage[i+1].w_rdy;
    end

    crypto_round_stage #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .STAGE_IDX   (i),
      .NUM_ROUNDS  (NUM_ROUNDS)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_key   (r_key),
      .i_valid (w_in_valid),
      .i_data  (w_in_data),
      .i_mode  (w_in_mode),
      .i_ready (w_dn_ready),
      .o_ready (w_rdy),
      .o_valid (w_valid),
      .o_data  (w_data),
      .o_mode  (w_mode)
    );

    assign w_stage_valid[i] = w_valid;
  end

  assign data_in_ready  = g_stage[0].w_rdy;
  assign data_out_valid = g_stage[LAST].w_valid;
  assign data_out       = g_stage[LAST].w_data;
  assign data_out_mode  = logic'(g_stage[LAST].w_mode);

  assign w_busy       = |w_stage_valid;
  assign busy         = w_busy;
  assign key_load_err = r_key_err;

  // A key swap is only safe with the pipe empty and nothing arriving, so
  // every in-flight block sees one consistent schedule; otherwise flag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key     <= KEY_RESET;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= 1'b0;
      if (key_load) begin
        if (!w_busy && !data_in_valid) begin
          r_key <= key_in;
        end else begin
          r_key_err <= 1'b1;
        end
      end
    end
  end

`ifdef CRYPTO_PERF_CNT_EN
  logic [COUNTER_WIDTH-1:0] r_blocks;
  logic [COUNTER_WIDTH-1:0] r_cycles;
  logic                     r_started;
  logic                     w_in_hs;
  logic                     w_out_hs;

  assign w_in_hs  = data_in_valid && data_in_ready;
  assign w_out_hs = data_out_valid && data_out_ready;

  // Saturating counters; the cycle count includes the cycle of the first
  // accepted block, so it reads 1 right after that block is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blocks  <= '0;
      r_cycles  <= '0;
      r_started <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_started <= 1'b1;
      end
      if (w_out_hs && (r_blocks != '1)) begin
        r_blocks <= r_blocks + COUNTER_WIDTH'(1);
      end
      if ((r_started || w_in_hs) && (r_cycles != '1)) begin
        r_cycles <= r_cycles + COUNTER_WIDTH'(1);
      end
    end
  end

  assign blocks_processed = r_blocks;
  assign cycles_elapsed   = r_cycles;
`else
  assign blocks_processed = '0;
  assign cycles_elapsed   = '0;
`endif

endmodule

// File: tb/tb_crypto_stream_engine.sv
// Self-checking bench for crypto_stream_engine: a one-round instance for the
// single-stage vector and an eight-round instance driven with random traffic
// against a behavioural model of the cipher and an in-order scoreboard.
module tb_crypto_stream_engine;

  localparam int NR = 8;
  localparam int CW = 10;

  logic          clk;
  logic          rst;

  logic [31:0]   dataIn;
  logic          dataInMode;
  logic          dataInValid;
  logic          dataInReady;
  logic [31:0]   dataOut;
  logic          dataOutMode;
  logic          dataOutValid;
  logic          dataOutReady;
  logic [31:0]   keyIn;
  logic          keyLoad;
  logic          keyLoadErr;
  logic          busy;
  logic [CW-1:0] blocksProcessed;
  logic [CW-1:0] cyclesElapsed;

  logic [31:0]   d1In;
  logic          d1InMode;
  logic          d1InValid;
  logic          d1InReady;
  logic [31:0]   d1Out;
  logic          d1OutMode;
  logic          d1OutValid;
  logic          d1OutReady;
  logic          d1KeyErr;
  logic          d1Busy;
  logic [31:0]   d1Blocks;
  logic [31:0]   d1Cycles;

  int            checks;
  int            errors;
  int            readyPct;
  int            validPct;
  int            firstAccIter;
  int            lastOutIter;
  logic [31:0]   modelKey;
  logic [31:0]   srcData[$];
  logic          srcMode[$];
  logic [32:0]   expQ[$];
  logic [31:0]   resData[$];
  logic [31:0]   plain[$];

  crypto_stream_engine #(
    .BLOCK_WIDTH   (32),
    .NUM_ROUNDS    (NR),
    .KEY_RESET     (32'hDEADBEEF),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (dataIn),
    .data_in_mode     (dataInMode),
    .data_in_valid    (dataInValid),
    .data_in_ready    (dataInReady),
    .data_out         (dataOut),
    .data_out_mode    (dataOutMode),
    .data_out_valid   (dataOutValid),
    .data_out_ready   (dataOutReady),
    .key_in           (keyIn),
    .key_load         (keyLoad),
    .key_load_err     (keyLoadErr),
    .busy             (busy),
    .blocks_processed (blocksProcessed),
    .cycles_elapsed   (cyclesElapsed)
  );

  crypto_stream_engine #(
    .BLOCK_WIDTH   (32),
    .NUM_ROUNDS    (1),
    .KEY_RESET     (32'hDEADBEEF),
    .COUNTER_WIDTH (32)
  ) dutOne (
    .clk              (clk),
    .rst              (rst),
    .data_in          (d1In),
    .data_in_mode     (d1InMode),
    .data_in_valid    (d1InValid),
    .data_in_ready    (d1InReady),
    .data_out         (d1Out),
    .data_out_mode    (d1OutMode),
    .data_out_valid   (d1OutValid),
    .data_out_ready   (d1OutReady),
    .key_in           (32'h0),
    .key_load         (1'b0),
    .key_load_err     (d1KeyErr),
    .busy             (d1Busy),
    .blocks_processed (d1Blocks),
    .cycles_elapsed   (d1Cycles)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream of the bounded loops misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cipher straight from the round rules, on 32-bit blocks with NR rounds.
  function automatic logic [31:0] modelCrypt(input logic [31:0] x, input logic mode,
                                             input logic [31:0] key);
    logic [31:0] v;
    logic [31:0] rk;
    v = x;
    for (int s = 0; s < NR; s++) begin
      if (!mode) begin
        rk = key ^ (32'(s) << 24);
        v  = v ^ rk;
        v  = {v[30:0], v[31]};
      end else begin
        rk = key ^ (32'(NR - 1 - s) << 24);
        v  = {v[0], v[31:1]} ^ rk;
      end
    end
    return v;
  endfunction

  // Push the queued source blocks through the 8-round DUT under random
  // valid/ready, scoring every output in order and checking stall stability.
  task automatic applyStimulus(input string tag, input int maxCycles);
    int          iter;
    int          extra;
    bit          prevStall;
    logic [32:0] prevOut;
    logic [32:0] expv;
    iter         = 0;
    extra        = 0;
    prevStall    = 1'b0;
    prevOut      = '0;
    firstAccIter = -1;
    lastOutIter  = -1;
    while ((srcData.size() > 0 || expQ.size() > 0) && iter < maxCycles) begin
      @(negedge clk);
      keyLoad      = 1'b0;
      dataOutReady = (int'($urandom_range(99)) < readyPct);
      if (srcData.size() > 0 && (int'($urandom_range(99)) < validPct)) begin
        dataInValid = 1'b1;
        dataIn      = srcData[0];
        dataInMode  = srcMode[0];
      end else begin
        dataInValid = 1'b0;
        dataIn      = $urandom;
        dataInMode  = 1'($urandom);
      end
      #1;
      if (prevStall) begin
        checkOutput({tag, "_hold"}, 64'({dataOutValid, dataOutMode, dataOut}),
                    64'({1'b1, prevOut}));
      end
      if (dataInValid && dataInReady) begin
        expQ.push_back({srcMode[0], modelCrypt(srcData[0], srcMode[0], modelKey)});
        void'(srcData.pop_front());
        void'(srcMode.pop_front());
        if (firstAccIter < 0) firstAccIter = iter;
      end
      if (dataOutValid && dataOutReady) begin
        if (expQ.size() == 0) begin
          extra++;
        end else begin
          expv = expQ.pop_front();
          checkOutput({tag, "_out"}, 64'({dataOutMode, dataOut}), 64'(expv));
          resData.push_back(dataOut);
        end
        lastOutIter = iter;
      end
      prevStall = dataOutValid && !dataOutReady;
      prevOut   = {dataOutMode, dataOut};
      iter++;
    end
    checkOutput({tag, "_left"}, 64'(srcData.size() + expQ.size()), 64'd0);
    checkOutput({tag, "_extra"}, 64'(extra), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    int accepted;
    int stale;

    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    dataIn       = '0;
    dataInMode   = 1'b0;
    dataInValid  = 1'b0;
    dataOutReady = 1'b1;
    keyIn        = '0;
    keyLoad      = 1'b0;
    d1In         = '0;
    d1InMode     = 1'b0;
    d1InValid    = 1'b0;
    d1OutReady   = 1'b1;
    readyPct     = 100;
    validPct     = 100;
    modelKey     = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset released");
    checkOutput("rst_valid",   64'(dataOutValid),    64'd0);
    checkOutput("rst_data",    64'(dataOut),         64'd0);
    checkOutput("rst_mode",    64'(dataOutMode),     64'd0);
    checkOutput("rst_busy",    64'(busy),            64'd0);
    checkOutput("rst_err",     64'(keyLoadErr),      64'd0);
    checkOutput("rst_blocks",  64'(blocksProcessed), 64'd0);
    checkOutput("rst_cycles",  64'(cyclesElapsed),   64'd0);
    checkOutput("rst_inready", 64'(dataInReady),     64'd1);
    checkOutput("rst_d1valid", 64'(d1OutValid),      64'd0);

    // T1: single round, encrypt zero with the reset key, then decrypt back.
    $display("[TB] T1 single-round vector");
    @(negedge clk);
    d1InValid = 1'b1;
    d1In      = 32'h0;
    d1InMode  = 1'b0;
    #1;
    checkOutput("t1_inready", 64'(d1InReady), 64'd1);
    @(negedge clk);
    d1In     = 32'hBD5B7DDF;
    d1InMode = 1'b1;
    #1;
    checkOutput("t1_enc_out", 64'({d1OutValid, d1OutMode, d1Out}), 64'({2'b10, 32'hBD5B7DDF}));
    @(negedge clk);
    d1InValid = 1'b0;
    #1;
    checkOutput("t1_dec_out", 64'({d1OutValid, d1OutMode, d1Out}), 64'({2'b11, 32'h0}));
    @(negedge clk);
    #1;
    checkOutput("t1_drained", 64'(d1OutValid), 64'd0);

    // T2: 1000 back-to-back random blocks with the output always ready.
    $display("[TB] T2 full-rate stream");
    for (int i = 0; i < 1000; i++) begin
      srcData.push_back($urandom);
      srcMode.push_back(1'($urandom));
    end
    readyPct = 100;
    validPct = 100;
    applyStimulus("t2", 2000);
    checkOutput("t2_span", 64'(lastOutIter - firstAccIter), 64'd1007);
    @(negedge clk);
    dataInValid = 1'b0;
    #1;
`ifdef CRYPTO_PERF_CNT_EN
    checkOutput("t2_blocks", 64'(blocksProcessed), 64'd1000);
    checkOutput("t2_cycles", 64'(cyclesElapsed),   64'd1008);
`else
    checkOutput("t2_blocks_off", 64'(blocksProcessed), 64'd0);
    checkOutput("t2_cycles_off", 64'(cyclesElapsed),   64'd0);
`endif

    // T3: random backpressure and mixed modes, then fill with output held off.
    $display("[TB] T3 backpressure");
    for (int i = 0; i < 300; i++) begin
      srcData.push_back($urandom);
      srcMode.push_back(1'($urandom));
    end
    readyPct = 50;
    validPct = 70;
    applyStimulus("t3", 5000);
    @(negedge clk);
    #1;
`ifdef CRYPTO_PERF_CNT_EN
    checkOutput("t3_blocks_sat", 64'(blocksProcessed), 64'(10'h3FF));
    checkOutput("t3_cycles_sat", 64'(cyclesElapsed),   64'(10'h3FF));
`endif
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dataOutReady = 1'b0;
      dataInValid  = 1'b1;
      dataIn       = $urandom;
      dataInMode   = 1'($urandom);
      #1;
      if (dataInReady) begin
        accepted++;
        expQ.push_back({dataInMode, modelCrypt(dataIn, dataInMode, modelKey)});
      end
    end
    checkOutput("t3_fill_count", 64'(accepted),    64'(NR));
    checkOutput("t3_fill_busy",  64'(busy),        64'd1);
    checkOutput("t3_fill_ready", 64'(dataInReady), 64'd0);
    @(negedge clk);
    dataInValid = 1'b0;
    readyPct    = 100;
    applyStimulus("t3_drain", 100);

    // T4: encrypt a batch, feed the ciphertexts back as decrypts.
    $display("[TB] T4 round trip");
    plain.delete();
    resData.delete();
    for (int i = 0; i < 64; i++) begin
      plain.push_back($urandom);
      srcData.push_back(plain[i]);
      srcMode.push_back(1'b0);
    end
    readyPct = 70;
    validPct = 80;
    applyStimulus("t4_enc", 1000);
    for (int i = 0; i < resData.size(); i++) begin
      srcData.push_back(resData[i]);
      srcMode.push_back(1'b1);
    end
    resData.delete();
    applyStimulus("t4_dec", 1000);
    checkOutput("t4_count", 64'(resData.size()), 64'd64);
    for (int i = 0; i < resData.size() && i < 64; i++) begin
      checkOutput("t4_roundtrip", 64'(resData[i]), 64'(plain[i]));
    end

    // T5: key load rejected while busy or while a block arrives, then taken idle.
    $display("[TB] T5 key load");
    @(negedge clk);
    dataOutReady = 1'b0;
    dataInValid  = 1'b1;
    dataIn       = 32'hAAAA5555;
    dataInMode   = 1'b0;
    keyLoad      = 1'b0;
    #1;
    checkOutput("t5_accept", 64'(dataInReady), 64'd1);
    expQ.push_back({1'b0, modelCrypt(32'hAAAA5555, 1'b0, modelKey)});
    @(negedge clk);
    dataInValid = 1'b0;
    keyLoad     = 1'b1;
    keyIn       = 32'h01234567;
    #1;
    checkOutput("t5_busy", 64'(busy), 64'd1);
    @(negedge clk);
    keyLoad = 1'b0;
    #1;
    checkOutput("t5_err_busy", 64'(keyLoadErr), 64'd1);
    @(negedge clk);
    #1;
    checkOutput("t5_err_pulse", 64'(keyLoadErr), 64'd0);
    readyPct = 100;
    validPct = 100;
    applyStimulus("t5_old", 100);

    @(negedge clk);
    dataOutReady = 1'b1;
    dataInValid  = 1'b1;
    dataIn       = 32'h0;
    dataInMode   = 1'b0;
    keyLoad      = 1'b1;
    keyIn        = 32'h01234567;
    #1;
    checkOutput("t5_idle_pipe", 64'(busy),        64'd0);
    checkOutput("t5_in_ready",  64'(dataInReady), 64'd1);
    expQ.push_back({1'b0, modelCrypt(32'h0, 1'b0, modelKey)});
    @(negedge clk);
    dataInValid = 1'b0;
    keyLoad     = 1'b0;
    #1;
    checkOutput("t5_err_valid", 64'(keyLoadErr), 64'd1);
    applyStimulus("t5_keep", 100);

    @(negedge clk);
    dataInValid = 1'b0;
    keyLoad     = 1'b1;
    keyIn       = 32'h01234567;
    #1;
    checkOutput("t5_load_idle", 64'(busy), 64'd0);
    @(negedge clk);
    keyLoad = 1'b0;
    #1;
    checkOutput("t5_err_idle", 64'(keyLoadErr), 64'd0);
    modelKey = 32'h01234567;
    srcData.push_back(32'h0);
    srcMode.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      srcData.push_back($urandom);
      srcMode.push_back(1'($urandom));
    end
    applyStimulus("t5_new", 200);

    // T6: reset with blocks in flight and a competing key load.
    $display("[TB] T6 reset in flight");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dataOutReady = 1'b0;
      dataInValid  = 1'b1;
      dataIn       = $urandom;
      dataInMode   = 1'($urandom);
      #1;
      checkOutput("t6_fill_ready", 64'(dataInReady), 64'd1);
    end
    @(negedge clk);
    dataInValid  = 1'b0;
    rst          = 1'b1;
    keyLoad      = 1'b1;
    keyIn        = 32'h55555555;
    dataOutReady = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    keyLoad = 1'b0;
    #1;
    checkOutput("t6_valid",  64'(dataOutValid),    64'd0);
    checkOutput("t6_data",   64'({dataOutMode, dataOut}), 64'd0);
    checkOutput("t6_busy",   64'(busy),            64'd0);
    checkOutput("t6_err",    64'(keyLoadErr),      64'd0);
    checkOutput("t6_blocks", 64'(blocksProcessed), 64'd0);
    checkOutput("t6_cycles", 64'(cyclesElapsed),   64'd0);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      if (dataOutValid) stale++;
    end
    checkOutput("t6_stale", 64'(stale), 64'd0);
    expQ.delete();
    srcData.delete();
    srcMode.delete();
    modelKey = 32'hDEADBEEF;
    srcData.push_back(32'h0);
    srcMode.push_back(1'b0);
    for (int i = 0; i < 19; i++) begin
      srcData.push_back($urandom);
      srcMode.push_back(1'($urandom));
    end
    readyPct = 60;
    validPct = 80;
    applyStimulus("t6_post", 500);
    @(negedge clk);
    dataInValid = 1'b0;
    #1;
`ifdef CRYPTO_PERF_CNT_EN
    checkOutput("t6_blocks_post", 64'(blocksProcessed), 64'd20);
`else
    checkOutput("t6_blocks_off", 64'(blocksProcessed), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
